// File: rtl/swan_bus_initiator_if.sv
// swan_bus_initiator_if: request/response handshake plus WonderSwan cartridge bus signals.
// master is the initiator view; slave is the requester and cartridge side.
interface swan_bus_initiator_if;
   logic        ReqValid;
   logic        ReqReady;
   logic        ReqWrite;
   logic        ReqIO;
   logic [11:0] ReqAddr;
   logic [15:0] ReqData;
   logic        RspValid;
   logic [15:0] RspData;
   logic        nSel;
   logic        nIO;
   logic        nOE;
   logic        nWE;
   logic [3:0]  AddrHi;
   logic [7:0]  AddrLo;
   logic [15:0] DataOut;
   logic        DataOE;
   logic [15:0] DataIn;
   modport master (
      input  ReqValid, ReqWrite, ReqIO, ReqAddr, ReqData, DataIn,
      output ReqReady, RspValid, RspData, nSel, nIO, nOE, nWE, AddrHi, AddrLo, DataOut, DataOE
   );
   modport slave (
      output ReqValid, ReqWrite, ReqIO, ReqAddr, ReqData, DataIn,
      input  ReqReady, RspValid, RspData, nSel, nIO, nOE, nWE, AddrHi, AddrLo, DataOut, DataOE
   );
endinterface

// File: rtl/swan_bus_initiator.sv
// swan_bus_initiator: turns one valid/ready request into a timed WonderSwan cartridge bus cycle
// (SETUP, STROBE, HOLD) with registered bus outputs and a one-cycle read response strobe.
module swan_bus_initiator #(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 2
) (
   input logic FastClk,
   input logic Reset,
   swan_bus_initiator_if.master bus
);
   localparam int M1   = SETUP_CYCLES > STROBE_CYCLES ? SETUP_CYCLES : STROBE_CYCLES;
   localparam int MAXC = M1 > HOLD_CYCLES ? M1 : HOLD_CYCLES;
   localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_write;
   logic          r_io;
   logic          w_last;
   assign w_last       = r_cnt == '0;
   assign bus.ReqReady = r_state == IDLE;
   // Counter is loaded with dwell-1 on entry, so a state ends when it reaches zero.
   always_ff @(posedge FastClk) begin
      if (Reset) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_write      <= 1'b0;
         r_io         <= 1'b0;
         bus.nSel     <= 1'b1;
         bus.nIO      <= 1'b1;
         bus.nOE      <= 1'b1;
         bus.nWE      <= 1'b1;
         bus.DataOE   <= 1'b0;
         bus.DataOut  <= '0;
         bus.AddrHi   <= '0;
         bus.AddrLo   <= '0;
         bus.RspValid <= 1'b0;
         bus.RspData  <= '0;
      end else begin
         bus.RspValid <= 1'b0;
         r_cnt        <= r_cnt - 1'b1;
         case (r_state)
            IDLE: if (bus.ReqValid) begin
               r_state                  <= SETUP;
               r_cnt                    <= CW'(SETUP_CYCLES - 1);
               r_write                  <= bus.ReqWrite;
               r_io                     <= bus.ReqIO;
               {bus.AddrHi, bus.AddrLo} <= bus.ReqAddr;
               bus.DataOut              <= bus.ReqData;
               bus.nSel                 <= bus.ReqIO;
               bus.nIO                  <= !bus.ReqIO;
               bus.DataOE               <= bus.ReqWrite;
            end
            SETUP: if (w_last) begin
               r_state <= STROBE;
               r_cnt   <= CW'(STROBE_CYCLES - 1);
               bus.nOE <= r_write;
               bus.nWE <= !r_write;
            end
            STROBE: if (w_last) begin
               r_state <= HOLD;
               r_cnt   <= CW'(HOLD_CYCLES - 1);
               bus.nOE <= 1'b1;
               bus.nWE <= 1'b1;
               if (!r_write) begin
                  bus.RspData  <= bus.DataIn;
                  bus.RspValid <= 1'b1;
               end
            end
            HOLD: if (w_last) begin
               r_state    <= IDLE;
               bus.nSel   <= 1'b1;
               bus.nIO    <= 1'b1;
               bus.DataOE <= 1'b0;
            end
         endcase
      end
   end
endmodule
